// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer for the pipelined fetch stage
//
// Holds the fetch PC and the NZCV flag register. Evaluates the branch
// condition against the registered flags and picks the next PC: sequential,
// PC-relative, absolute or register-indirect. Includes start/halt control,
// a stall hold, a one-cycle flush pulse after a taken branch and a link
// (return) address.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        level; IDLE->RUN when high, HALTED->IDLE when low
//   halt         RUN->HALTED request; holds pc
//   stall        holds pc and suppresses branches (flags still load)
//   flags_we     load alu_flags into the flag register
//   alu_flags    {N,Z,C,V} from the execute stage
//   branch_valid branch present this cycle
//   branch_mode  00 none, 01 relative, 10 absolute, 11 register-indirect
//   cond         ARM condition code (E always, F never)
//   imm          branch immediate (signed word offset or byte address)
//   target_reg   register-indirect target
//   pc           current fetch address (registered)
//   running      high while in RUN
//   taken        combinational: branch accepted this cycle
//   flush        registered pulse in the cycle after taken
//   link_addr    pc + INSTR_BYTES, combinational
module pc_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int IMM_W       = 24,
  parameter int INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              flags_we,
  input  logic [3:0]        alu_flags,
  input  logic              branch_valid,
  input  logic [1:0]        branch_mode,
  input  logic [3:0]        cond,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] target_reg,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              taken,
  output logic              flush,
  output logic [ADDR_W-1:0] link_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [3:0]        flags;
  logic              cond_ok;
  logic [ADDR_W-1:0] imm_sx;
  logic [ADDR_W-1:0] target;

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags;

  // Condition evaluation sees only the registered flags, so a flag write in
  // the same cycle as a branch affects the next branch, not this one.
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = fz;
      4'h1: cond_ok = ~fz;
      4'h2: cond_ok = fc;
      4'h3: cond_ok = ~fc;
      4'h4: cond_ok = fn;
      4'h5: cond_ok = ~fn;
      4'h6: cond_ok = fv;
      4'h7: cond_ok = ~fv;
      4'h8: cond_ok = fc & ~fz;
      4'h9: cond_ok = ~fc | fz;
      4'hA: cond_ok = (fn == fv);
      4'hB: cond_ok = (fn != fv);
      4'hC: cond_ok = ~fz & (fn == fv);
      4'hD: cond_ok = fz | (fn != fv);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign imm_sx = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    target = pc + STEP;
    case (branch_mode)
      2'b01:   target = pc + (imm_sx << 2);
      2'b10:   target = {{(ADDR_W-IMM_W){1'b0}}, imm};
      2'b11:   target = target_reg;
      default: target = pc + STEP;
    endcase
  end

  assign running   = (state == RUN);
  assign link_addr = pc + STEP;
  assign taken     = running & ~stall & ~halt & branch_valid &
                     (branch_mode != 2'b00) & cond_ok;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = RESET_PC;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (stall) begin
          pc_nxt = pc;
        end else if (taken) begin
          pc_nxt = target;
        end else begin
          pc_nxt = pc + STEP;
        end
      end
      HALTED: begin
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      flags <= 4'b0000;
      flush <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      flush <= taken;
      if (flags_we) flags <= alu_flags;
    end
  end

endmodule
